rob_commit_queue: RTL and testbench

Reorder buffer for the out-of-order core. Dispatch allocates an entry in program order and receives the ROB index that travels with the instruction into the ALU, MULT, BR and MEM reservation stations. Completions from the four CDB ports mark entries done, and the queue retires at most one entry per cycle from the head. The head pointer is exported as `rob_read_ptr`; the reservation stations use it to compute issue age.

---
 rtl/rob_commit_queue_pkg.sv | 13 +
 rtl/rob_commit_queue.sv | 136 +++++++++++++
 tb/tb_rob_commit_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_queue_pkg.sv
// Shared types for the ROB: the CDB completion record broadcast by every functional unit.
// rob_idx is sized for ROBs of up to 256 entries; each consumer uses only the bits it needs.
package rob_commit_queue_pkg;

  localparam int CDB_IDX_WIDTH = 8;

  typedef struct packed {
    logic                     valid;
    logic [CDB_IDX_WIDTH-1:0] rob_idx;
    logic [31:0]              rd_v;
  } cdb_entry_t;

endpackage

// File: rtl/rob_commit_queue.sv
// Reorder buffer: in-order allocate, out-of-order completion from four CDB ports, in-order single commit.
// Optional ROB_RVFI_EN stores the completion value per entry and exports it as commit_rd_wdata.
module rob_commit_queue
  import rob_commit_queue_pkg::*;
#(
  parameter int ROB_DEPTH          = 16,
  parameter int ROB_PTR_WIDTH      = $clog2(ROB_DEPTH),
  parameter int PHYSICAL_REG_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq,
  input  logic [4:0]                    enq_arch_d_reg,
  input  logic [PHYSICAL_REG_WIDTH-1:0] enq_phys_d_reg,
  input  logic [PHYSICAL_REG_WIDTH-1:0] enq_old_phys_d_reg,
  output logic [ROB_PTR_WIDTH:0]        rob_alloc_ptr,
  output logic                          rob_full,
  output logic                          rob_empty,
  input  cdb_entry_t                    cdb_entry_alu,
  input  cdb_entry_t                    cdb_entry_mult,
  input  cdb_entry_t                    cdb_entry_br,
  input  cdb_entry_t                    cdb_entry_mem,
  input  logic                          flush_by_branch,
  input  logic [ROB_PTR_WIDTH:0]        flush_rob_idx,
  output logic [ROB_PTR_WIDTH:0]        rob_read_ptr,
  output logic                          commit_valid,
  output logic [4:0]                    commit_arch_d_reg,
  output logic [PHYSICAL_REG_WIDTH-1:0] commit_phys_d_reg,
  output logic [PHYSICAL_REG_WIDTH-1:0] commit_old_phys_d_reg,
  output logic [ROB_PTR_WIDTH:0]        commit_rob_idx
`ifdef ROB_RVFI_EN
  ,
  output logic [31:0]                   commit_rd_wdata
`endif
);

  localparam logic [ROB_PTR_WIDTH:0] PTR_ONE   = {{ROB_PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ROB_PTR_WIDTH:0] DEPTH_PTR = {1'b1, {ROB_PTR_WIDTH{1'b0}}};

  logic [ROB_PTR_WIDTH:0]          head, tail, count, flush_next, kill_span;
  logic [ROB_PTR_WIDTH-1:0]        head_slot, tail_slot, kill_off;
  logic [ROB_DEPTH-1:0]            valid_q, done_q, kill;
  logic [4:0]                      arch_q  [ROB_DEPTH];
  logic [PHYSICAL_REG_WIDTH-1:0]   phys_q  [ROB_DEPTH];
  logic [PHYSICAL_REG_WIDTH-1:0]   old_q   [ROB_DEPTH];
`ifdef ROB_RVFI_EN
  logic [31:0]                     data_q  [ROB_DEPTH];
`endif
  cdb_entry_t                      cdb     [4];
  logic                            enq_fire;
  logic                            unused_cdb_bits;

  // Upper rob_idx bits (and rd_v without RVFI) carry no information for this ROB.
  assign unused_cdb_bits = ^{cdb_entry_alu, cdb_entry_mult, cdb_entry_br, cdb_entry_mem};

  assign head_slot     = head[ROB_PTR_WIDTH-1:0];
  assign tail_slot     = tail[ROB_PTR_WIDTH-1:0];
  assign count         = tail - head;
  assign rob_full      = (count == DEPTH_PTR);
  assign rob_empty     = (head == tail);
  assign rob_alloc_ptr = tail;
  assign rob_read_ptr  = head;
  assign enq_fire      = enq && !rob_full && !flush_by_branch;
  assign commit_valid  = valid_q[head_slot] && done_q[head_slot];

  assign commit_arch_d_reg     = commit_valid ? arch_q[head_slot] : '0;
  assign commit_phys_d_reg     = commit_valid ? phys_q[head_slot] : '0;
  assign commit_old_phys_d_reg = commit_valid ? old_q[head_slot]  : '0;
  assign commit_rob_idx        = commit_valid ? head              : '0;
`ifdef ROB_RVFI_EN
  assign commit_rd_wdata       = commit_valid ? data_q[head_slot] : '0;
`endif

  // Lowest-priority port first so the later non-blocking write (alu) wins on a shared index.
  always_comb begin
    cdb[0] = cdb_entry_mem;
    cdb[1] = cdb_entry_br;
    cdb[2] = cdb_entry_mult;
    cdb[3] = cdb_entry_alu;
  end

  // Slot i is younger than the branch when its distance from branch+1 is below tail-(branch+1).
  always_comb begin
    flush_next = flush_rob_idx + PTR_ONE;
    kill_span  = tail - flush_next;
    kill       = '0;
    kill_off   = '0;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      kill_off = ROB_PTR_WIDTH'(i) - flush_next[ROB_PTR_WIDTH-1:0];
      kill[i]  = flush_by_branch && ({1'b0, kill_off} < kill_span);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      for (int unsigned p = 0; p < 4; p++) begin
        if (cdb[p].valid && valid_q[cdb[p].rob_idx[ROB_PTR_WIDTH-1:0]]) begin
          done_q[cdb[p].rob_idx[ROB_PTR_WIDTH-1:0]] <= 1'b1;
`ifdef ROB_RVFI_EN
          data_q[cdb[p].rob_idx[ROB_PTR_WIDTH-1:0]] <= cdb[p].rd_v;
`endif
        end
      end

      if (commit_valid) begin
        valid_q[head_slot] <= 1'b0;
        done_q[head_slot]  <= 1'b0;
        head               <= head + PTR_ONE;
      end

      // Kill is applied after completions so a same-cycle CDB hit on a flushed slot is discarded.
      if (flush_by_branch) begin
        for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
          if (kill[i]) begin
            valid_q[i] <= 1'b0;
            done_q[i]  <= 1'b0;
          end
        end
        tail <= flush_next;
      end else if (enq_fire) begin
        valid_q[tail_slot] <= 1'b1;
        done_q[tail_slot]  <= 1'b0;
        arch_q[tail_slot]  <= enq_arch_d_reg;
        phys_q[tail_slot]  <= enq_phys_d_reg;
        old_q[tail_slot]   <= enq_old_phys_d_reg;
        tail               <= tail + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed self-checking bench for rob_commit_queue (16 entries); ROB_RVFI_EN adds commit_rd_wdata checks.
module tb_rob_commit_queue;
  import rob_commit_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst, enq, flush_by_branch;
  logic [4:0] enq_arch_d_reg, rob_alloc_ptr, flush_rob_idx, rob_read_ptr, commit_rob_idx;
  logic [4:0] commit_arch_d_reg;
  logic [5:0] enq_phys_d_reg, enq_old_phys_d_reg, commit_phys_d_reg, commit_old_phys_d_reg;
  logic       rob_full, rob_empty, commit_valid;
  cdb_entry_t cdb_entry_alu, cdb_entry_mult, cdb_entry_br, cdb_entry_mem;
`ifdef ROB_RVFI_EN
  logic [31:0] commit_rd_wdata;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_commit_queue #(.ROB_DEPTH(16), .PHYSICAL_REG_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .enq(enq),
    .enq_arch_d_reg(enq_arch_d_reg), .enq_phys_d_reg(enq_phys_d_reg),
    .enq_old_phys_d_reg(enq_old_phys_d_reg),
    .rob_alloc_ptr(rob_alloc_ptr), .rob_full(rob_full), .rob_empty(rob_empty),
    .cdb_entry_alu(cdb_entry_alu), .cdb_entry_mult(cdb_entry_mult),
    .cdb_entry_br(cdb_entry_br), .cdb_entry_mem(cdb_entry_mem),
    .flush_by_branch(flush_by_branch), .flush_rob_idx(flush_rob_idx),
    .rob_read_ptr(rob_read_ptr), .commit_valid(commit_valid),
    .commit_arch_d_reg(commit_arch_d_reg), .commit_phys_d_reg(commit_phys_d_reg),
    .commit_old_phys_d_reg(commit_old_phys_d_reg), .commit_rob_idx(commit_rob_idx)
`ifdef ROB_RVFI_EN
    , .commit_rd_wdata(commit_rd_wdata)
`endif
  );

  function automatic cdb_entry_t mk(input int idx, input logic [31:0] d);
    cdb_entry_t c;
    c.valid   = 1'b1;
    c.rob_idx = 8'(idx);
    c.rd_v    = d;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enq = 1'b0; enq_arch_d_reg = '0; enq_phys_d_reg = '0; enq_old_phys_d_reg = '0;
    cdb_entry_alu = '0; cdb_entry_mult = '0; cdb_entry_br = '0; cdb_entry_mem = '0;
    flush_by_branch = 1'b0; flush_rob_idx = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [4:0] a, input logic [5:0] p, input logic [5:0] o);
    enq = 1'b1; enq_arch_d_reg = a; enq_phys_d_reg = p; enq_old_phys_d_reg = o;
    tick();
    enq = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", rob_empty); end
    checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", rob_full); end
    checks++; if (rob_read_ptr !== 5'd0) begin errors++; $display("FAIL reset_read_ptr got %0d want 0", rob_read_ptr); end
    checks++; if (rob_alloc_ptr !== 5'd0) begin errors++; $display("FAIL reset_alloc_ptr got %0d want 0", rob_alloc_ptr); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %0b want 0", commit_valid); end
    checks++; if ({commit_arch_d_reg, commit_phys_d_reg, commit_old_phys_d_reg, commit_rob_idx} !== 22'd0) begin
      errors++; $display("FAIL reset_commit_data got %h want 0", {commit_arch_d_reg, commit_phys_d_reg, commit_old_phys_d_reg, commit_rob_idx});
    end
  endtask

  task automatic test_inorder();
    do_reset();
    for (int i = 0; i < 3; i++) push(5'(i + 1), 6'(33 + i), 6'(i + 1));
    checks++; if (rob_alloc_ptr !== 5'd3) begin errors++; $display("FAIL inorder_alloc got %0d want 3", rob_alloc_ptr); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL inorder_no_early_commit got %0b want 0", commit_valid); end
    for (int k = 0; k < 3; k++) begin
      cdb_entry_alu = mk(k, 32'h100 + k);
      tick();
      checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL inorder_cv[%0d] got %0b want 1", k, commit_valid); end
      checks++; if (commit_phys_d_reg !== 6'(33 + k)) begin errors++; $display("FAIL inorder_phys[%0d] got %0d want %0d", k, commit_phys_d_reg, 33 + k); end
      checks++; if (commit_old_phys_d_reg !== 6'(k + 1)) begin errors++; $display("FAIL inorder_old[%0d] got %0d want %0d", k, commit_old_phys_d_reg, k + 1); end
      checks++; if (commit_arch_d_reg !== 5'(k + 1) || commit_rob_idx !== 5'(k)) begin
        errors++; $display("FAIL inorder_arch_idx[%0d] got %0d/%0d want %0d/%0d", k, commit_arch_d_reg, commit_rob_idx, k + 1, k);
      end
    end
    cdb_entry_alu = '0;
    tick();
    checks++; if (rob_empty !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL inorder_drained got empty=%0b cv=%0b want 1/0", rob_empty, commit_valid); end
    checks++; if (rob_read_ptr !== 5'd3) begin errors++; $display("FAIL inorder_head got %0d want 3", rob_read_ptr); end
  endtask

  task automatic test_ooo();
    do_reset();
    for (int i = 0; i < 4; i++) push(5'(10 + i), 6'(40 + i), 6'd0);
    cdb_entry_mult = mk(3, 32'h3); tick(); cdb_entry_mult = '0;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_wait3 got %0b want 0", commit_valid); end
    cdb_entry_br = mk(2, 32'h2); tick(); cdb_entry_br = '0;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_wait2 got %0b want 0", commit_valid); end
    cdb_entry_mem = mk(1, 32'h1); tick(); cdb_entry_mem = '0;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_wait1 got %0b want 0", commit_valid); end
    cdb_entry_alu = mk(0, 32'h0); tick(); cdb_entry_alu = '0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (commit_valid !== 1'b1 || commit_phys_d_reg !== 6'(40 + k) || commit_rob_idx !== 5'(k)) begin
        errors++; $display("FAIL ooo_commit[%0d] got cv=%0b phys=%0d idx=%0d want 1/%0d/%0d", k, commit_valid, commit_phys_d_reg, commit_rob_idx, 40 + k, k);
      end
      tick();
    end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL ooo_empty got %0b want 1", rob_empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) push(5'(i), 6'(i), 6'd0);
    checks++; if (rob_full !== 1'b1 || rob_empty !== 1'b0) begin errors++; $display("FAIL full_set got full=%0b empty=%0b want 1/0", rob_full, rob_empty); end
    checks++; if (rob_alloc_ptr !== 5'd16) begin errors++; $display("FAIL full_alloc got %0d want 16", rob_alloc_ptr); end
    push(5'd31, 6'd63, 6'd0);
    checks++; if (rob_alloc_ptr !== 5'd16 || rob_full !== 1'b1) begin errors++; $display("FAIL full_drop got alloc=%0d full=%0b want 16/1", rob_alloc_ptr, rob_full); end
    cdb_entry_alu = mk(0, 32'h0); tick(); cdb_entry_alu = '0;
    checks++; if (commit_valid !== 1'b1 || rob_full !== 1'b1) begin errors++; $display("FAIL full_commit_pending got cv=%0b full=%0b want 1/1", commit_valid, rob_full); end
    enq = 1'b1; enq_phys_d_reg = 6'd62; tick(); enq = 1'b0;
    checks++; if (rob_full !== 1'b0 || rob_read_ptr !== 5'd1 || rob_alloc_ptr !== 5'd16) begin
      errors++; $display("FAIL full_release got full=%0b head=%0d tail=%0d want 0/1/16", rob_full, rob_read_ptr, rob_alloc_ptr);
    end
    push(5'd20, 6'd50, 6'd9);
    checks++; if (rob_alloc_ptr !== 5'd17 || rob_full !== 1'b1) begin errors++; $display("FAIL full_wrap_enq got alloc=%0d full=%0b want 17/1", rob_alloc_ptr, rob_full); end
    for (int k = 1; k <= 16; k++) begin
      cdb_entry_alu = mk(k, 32'h0);
      tick();
    end
    cdb_entry_alu = '0;
    checks++; if (commit_valid !== 1'b1 || commit_phys_d_reg !== 6'd50 || commit_rob_idx !== 5'd16 || commit_arch_d_reg !== 5'd20) begin
      errors++; $display("FAIL full_wrap_commit got cv=%0b phys=%0d idx=%0d arch=%0d want 1/50/16/20", commit_valid, commit_phys_d_reg, commit_rob_idx, commit_arch_d_reg);
    end
    tick();
    checks++; if (rob_empty !== 1'b1 || rob_read_ptr !== 5'd17) begin errors++; $display("FAIL full_wrap_empty got empty=%0b head=%0d want 1/17", rob_empty, rob_read_ptr); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_d [8];
    exp_d = '{32'hA0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77};
    do_reset();
    for (int i = 0; i < 8; i++) push(5'(i), 6'(8 + i), 6'd0);
    cdb_entry_alu = mk(4, 32'h44); cdb_entry_mult = mk(5, 32'h55);
    cdb_entry_br  = mk(6, 32'h66); cdb_entry_mem  = mk(7, 32'h77);
    tick();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL simul_head_pending got %0b want 0", commit_valid); end
    cdb_entry_alu = mk(0, 32'hA0); cdb_entry_mult = mk(1, 32'h11);
    cdb_entry_br  = mk(2, 32'h22); cdb_entry_mem  = mk(0, 32'hD0);
    tick();
    cdb_entry_alu = '0; cdb_entry_mult = '0; cdb_entry_br = '0;
    cdb_entry_mem = mk(3, 32'h33);
    for (int k = 0; k < 8; k++) begin
      checks++; if (commit_valid !== 1'b1 || commit_phys_d_reg !== 6'(8 + k) || commit_rob_idx !== 5'(k)) begin
        errors++; $display("FAIL simul_commit[%0d] got cv=%0b phys=%0d idx=%0d want 1/%0d/%0d", k, commit_valid, commit_phys_d_reg, commit_rob_idx, 8 + k, k);
      end
`ifdef ROB_RVFI_EN
      checks++; if (commit_rd_wdata !== exp_d[k]) begin errors++; $display("FAIL simul_wdata[%0d] got %h want %h", k, commit_rd_wdata, exp_d[k]); end
`endif
      tick();
      cdb_entry_mem = '0;
    end
    checks++; if (rob_empty !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL simul_drained got empty=%0b cv=%0b want 1/0", rob_empty, commit_valid); end
`ifdef ROB_RVFI_EN
    checks++; if (commit_rd_wdata !== 32'd0) begin errors++; $display("FAIL simul_wdata_idle got %h want 0", commit_rd_wdata); end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) push(5'(i), 6'(20 + i), 6'd0);
    cdb_entry_alu = mk(0, 32'h0); tick(); cdb_entry_alu = '0;
    flush_by_branch = 1'b1; flush_rob_idx = 5'd5;
    enq = 1'b1; enq_arch_d_reg = 5'd30; enq_phys_d_reg = 6'd60;
    cdb_entry_mem = mk(8, 32'h88);
    tick();
    idle_inputs();
    checks++; if (rob_alloc_ptr !== 5'd6) begin errors++; $display("FAIL flush_tail got %0d want 6", rob_alloc_ptr); end
    checks++; if (rob_read_ptr !== 5'd1 || rob_empty !== 1'b0) begin errors++; $display("FAIL flush_same_cycle_commit got head=%0d empty=%0b want 1/0", rob_read_ptr, rob_empty); end
    push(5'd7, 6'd70, 6'd0);
    checks++; if (rob_alloc_ptr !== 5'd7) begin errors++; $display("FAIL flush_realloc got %0d want 7", rob_alloc_ptr); end
    cdb_entry_alu = mk(1, 32'h0); cdb_entry_mult = mk(2, 32'h0);
    cdb_entry_br  = mk(3, 32'h0); cdb_entry_mem  = mk(4, 32'h0);
    tick();
    cdb_entry_alu = mk(5, 32'h0); cdb_entry_mult = mk(6, 32'h0);
    cdb_entry_br  = '0;           cdb_entry_mem  = '0;
    for (int k = 1; k <= 6; k++) begin
      checks++; if (commit_valid !== 1'b1 || commit_rob_idx !== 5'(k) || commit_phys_d_reg !== ((k == 6) ? 6'd70 : 6'(20 + k))) begin
        errors++; $display("FAIL flush_commit[%0d] got cv=%0b idx=%0d phys=%0d want 1/%0d/%0d", k, commit_valid, commit_rob_idx, commit_phys_d_reg, k, (k == 6) ? 70 : 20 + k);
      end
      tick();
      cdb_entry_alu = '0; cdb_entry_mult = '0;
    end
    checks++; if (rob_empty !== 1'b1 || commit_valid !== 1'b0 || rob_read_ptr !== 5'd7) begin
      errors++; $display("FAIL flush_drained got empty=%0b cv=%0b head=%0d want 1/0/7", rob_empty, commit_valid, rob_read_ptr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) push(5'(i), 6'(i + 1), 6'd0);
    cdb_entry_alu = mk(0, 32'h0); tick(); cdb_entry_alu = '0;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %0b want 1", commit_valid); end
    rst = 1'b1; enq = 1'b1; enq_phys_d_reg = 6'd44;
    tick();
    rst = 1'b0; enq = 1'b0;
    checks++; if (rob_empty !== 1'b1 || rob_full !== 1'b0 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags got empty=%0b full=%0b cv=%0b want 1/0/0", rob_empty, rob_full, commit_valid);
    end
    checks++; if (rob_read_ptr !== 5'd0 || rob_alloc_ptr !== 5'd0 || commit_phys_d_reg !== 6'd0) begin
      errors++; $display("FAIL rstmid_ptrs got head=%0d tail=%0d phys=%0d want 0/0/0", rob_read_ptr, rob_alloc_ptr, commit_phys_d_reg);
    end
    cdb_entry_alu = mk(1, 32'h0); tick(); cdb_entry_alu = '0;
    checks++; if (rob_empty !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stay_empty got empty=%0b cv=%0b want 1/0", rob_empty, commit_valid); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_inorder();
    test_ooo();
    test_full();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
